// File: rtl/udc_mon_pkg.sv
// Shared types and default sizes for the up/down count monitor.
// State and step-class enums are used by the top and the step classifier.
package udc_mon_pkg;

    localparam int UDC_WIDTH_DEF = 4;
    localparam int UDC_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        UP,
        DOWN
    } mon_state_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_INC,
        STEP_DEC,
        STEP_BAD
    } step_class_t;

endpackage

// File: rtl/udc_step_classifier.sv
// Combinational step classifier: compares the sampled count against the reference
// modulo 2^WIDTH and flags whether the reference sits at either end of the range.
module udc_step_classifier
    import udc_mon_pkg::*;
#(
    parameter int WIDTH = UDC_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] ref_val,
    input  logic [WIDTH-1:0] count_in,
    output step_class_t      step_class,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] delta;

    // Unsigned subtraction wraps naturally, so -1 shows up as all ones.
    assign delta   = count_in - ref_val;
    assign at_max  = (ref_val == '1);
    assign at_zero = (ref_val == '0);

    always_comb begin
        step_class = STEP_BAD;
        if (delta == '0)
            step_class = STEP_HOLD;
        else if (delta == WIDTH'(1))
            step_class = STEP_INC;
        else if (delta == '1)
            step_class = STEP_DEC;
    end

endmodule

// File: rtl/up_down_count_monitor.sv
// Observer for an up/down counter bus: infers direction and reports holds, wraps,
// direction changes and illegal jumps. Define UDC_MON_STICKY_ERR_EN to add err_flag.
//
// state | meaning
// SYNC  | no reference captured yet
// IDLE  | reference held, direction unknown
// UP    | last legal step was +1
// DOWN  | last legal step was -1
module up_down_count_monitor
    import udc_mon_pkg::*;
#(
    parameter int WIDTH = UDC_WIDTH_DEF,
    parameter int CNT_W = UDC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             resync,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_valid,
    output logic             dir_up,
    output logic             hold,
    output logic             wrap,
    output logic             dir_change,
    output logic             step_err,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef UDC_MON_STICKY_ERR_EN
    ,
    output logic             err_flag
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_t       state;
    logic [WIDTH-1:0] ref_q;
    step_class_t      step_class;
    logic             at_max;
    logic             at_zero;

    udc_step_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .ref_val    (ref_q),
        .count_in   (count_in),
        .step_class (step_class),
        .at_max     (at_max),
        .at_zero    (at_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            ref_q      <= '0;
            dir_valid  <= 1'b0;
            dir_up     <= 1'b0;
            hold       <= 1'b0;
            wrap       <= 1'b0;
            dir_change <= 1'b0;
            step_err   <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
`ifdef UDC_MON_STICKY_ERR_EN
            err_flag   <= 1'b0;
`endif
        end else begin
            hold       <= 1'b0;
            wrap       <= 1'b0;
            dir_change <= 1'b0;
            step_err   <= 1'b0;

            if (resync) begin
                state     <= IDLE;
                ref_q     <= count_in;
                dir_valid <= 1'b0;
                dir_up    <= 1'b0;
            end else if (sample_en) begin
                ref_q <= count_in;
                if (state == SYNC) begin
                    state <= IDLE;
                end else begin
                    case (step_class)
                        STEP_HOLD: begin
                            hold <= 1'b1;
                        end
                        STEP_INC: begin
                            state      <= UP;
                            dir_valid  <= 1'b1;
                            dir_up     <= 1'b1;
                            wrap       <= at_max;
                            dir_change <= (state == DOWN);
                            if (at_max && wrap_cnt != CNT_MAX)
                                wrap_cnt <= wrap_cnt + CNT_W'(1);
                        end
                        STEP_DEC: begin
                            state      <= DOWN;
                            dir_valid  <= 1'b1;
                            dir_up     <= 1'b0;
                            wrap       <= at_zero;
                            dir_change <= (state == UP);
                            if (at_zero && wrap_cnt != CNT_MAX)
                                wrap_cnt <= wrap_cnt + CNT_W'(1);
                        end
                        default: begin
                            // An illegal jump means the direction can no longer be trusted.
                            state     <= IDLE;
                            dir_valid <= 1'b0;
                            dir_up    <= 1'b0;
                            step_err  <= 1'b1;
                            if (err_cnt != CNT_MAX)
                                err_cnt <= err_cnt + CNT_W'(1);
`ifdef UDC_MON_STICKY_ERR_EN
                            err_flag  <= 1'b1;
`endif
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Randomized self-checking bench for up_down_count_monitor against a reference model
// that tracks the last value and direction with plain modular arithmetic.
module tb_up_down_count_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int MOD   = 1 << WIDTH;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             sample_en;
    logic             resync;
    logic [WIDTH-1:0] count_in;
    logic             dir_valid;
    logic             dir_up;
    logic             hold;
    logic             wrap;
    logic             dir_change;
    logic             step_err;
    logic [CNT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef UDC_MON_STICKY_ERR_EN
    logic             err_flag;
`endif

    up_down_count_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .resync     (resync),
        .count_in   (count_in),
        .dir_valid  (dir_valid),
        .dir_up     (dir_up),
        .hold       (hold),
        .wrap       (wrap),
        .dir_change (dir_change),
        .step_err   (step_err),
        .wrap_cnt   (wrap_cnt),
        .err_cnt    (err_cnt)
`ifdef UDC_MON_STICKY_ERR_EN
        ,
        .err_flag   (err_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model: whether a reference exists, last value, direction (+1 up, -1 down, 0 none)
    bit m_has_ref;
    int m_ref;
    int m_dir;
    int m_wrap_cnt;
    int m_err_cnt;
    bit m_flag;
    bit e_hold, e_wrap, e_dc, e_err;
    int last_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_update(input bit r, input bit rs, input bit en, input int c);
        int d;
        e_hold = 0; e_wrap = 0; e_dc = 0; e_err = 0;
        if (r) begin
            m_has_ref = 0; m_ref = 0; m_dir = 0;
            m_wrap_cnt = 0; m_err_cnt = 0; m_flag = 0;
        end else if (rs) begin
            m_has_ref = 1; m_ref = c; m_dir = 0;
        end else if (en) begin
            if (!m_has_ref) begin
                m_has_ref = 1;
            end else begin
                d = ((c - m_ref) % MOD + MOD) % MOD;
                if (d == 0) begin
                    e_hold = 1;
                end else if (d == 1) begin
                    e_wrap = (m_ref == MOD - 1);
                    e_dc   = (m_dir == -1);
                    m_dir  = 1;
                end else if (d == MOD - 1) begin
                    e_wrap = (m_ref == 0);
                    e_dc   = (m_dir == 1);
                    m_dir  = -1;
                end else begin
                    e_err = 1;
                    m_dir = 0;
                    m_flag = 1;
                    if (m_err_cnt < CMAX) m_err_cnt++;
                end
                if (e_wrap && m_wrap_cnt < CMAX) m_wrap_cnt++;
            end
            m_ref = c;
        end
    endtask

    task automatic step(input bit r, input bit rs, input bit en, input int c);
        @(negedge clk);
        rst = r; resync = rs; sample_en = en; count_in = WIDTH'(c);
        @(posedge clk);
        model_update(r, rs, en, c);
        last_cnt = c;
        #1;
        chk("dir_valid", int'(dir_valid), int'(m_dir != 0));
        if (m_dir != 0 || r)
            chk("dir_up", int'(dir_up), int'(m_dir == 1));
        chk("hold", int'(hold), int'(e_hold));
        chk("wrap", int'(wrap), int'(e_wrap));
        chk("dir_change", int'(dir_change), int'(e_dc));
        chk("step_err", int'(step_err), int'(e_err));
        chk("wrap_cnt", int'(wrap_cnt), m_wrap_cnt);
        chk("err_cnt", int'(err_cnt), m_err_cnt);
`ifdef UDC_MON_STICKY_ERR_EN
        chk("err_flag", int'(err_flag), int'(m_flag));
`endif
    endtask

    task automatic samp(input int c);
        step(0, 0, 1, c);
    endtask

    initial begin
        int rnd;
        int c;
        rst = 1; resync = 0; sample_en = 0; count_in = '0; last_cnt = 0;

        // reset state
        step(1, 0, 0, 0);
        chk("reset_dir_valid", int'(dir_valid), 0);
        chk("reset_wrap_cnt", int'(wrap_cnt), 0);

        // count up through a wrap
        for (int i = 0; i < 18; i++) samp(i % MOD);
        chk("t1_wrap_cnt", int'(wrap_cnt), 1);
        chk("t1_dir_up", int'(dir_up), 1);

        // down, hold, reversal
        samp(5); samp(4); samp(3); samp(3); samp(4);
        chk("t2_dir_change", int'(dir_change), 1);

        // downward wrap
        samp(1); samp(0); samp(15);
        chk("t3_wrap", int'(wrap), 1);
        chk("t3_dir_up", int'(dir_up), 0);

        // illegal jump then legal step from IDLE
        samp(3); samp(9);
        chk("t4_step_err", int'(step_err), 1);
        samp(10);
        chk("t4_no_dc", int'(dir_change), 0);

        // resync across a counter reset
        samp(7);
        step(0, 1, 1, 0);
        samp(1);
        chk("t5_dir_up", int'(dir_up), 1);

        // sample_en low holds everything
        step(0, 0, 0, 9);
        samp(2);

        // randomized mix
        for (int i = 0; i < 3000; i++) begin
            bit r, rs, en;
            rnd = $urandom_range(0, 99);
            if (rnd < 40)      c = (last_cnt + 1) % MOD;
            else if (rnd < 70) c = (last_cnt + MOD - 1) % MOD;
            else if (rnd < 82) c = last_cnt;
            else               c = $urandom_range(0, MOD - 1);
            r  = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 9) != 0);
            step(r, rs, en, c);
        end

        // saturate the wrap counter
        step(0, 1, 0, 0);
        for (int i = 1; i <= 270 * MOD; i++) samp(i % MOD);
        chk("wrap_sat", int'(wrap_cnt), CMAX);

        // saturate the error counter
        c = 0;
        for (int i = 0; i < 300; i++) begin
            c = (c + 5) % MOD;
            samp(c);
        end
        chk("err_sat", int'(err_cnt), CMAX);
`ifdef UDC_MON_STICKY_ERR_EN
        step(0, 1, 1, 3);
        samp(4);
        chk("flag_held", int'(err_flag), 1);
`endif

        // reset mid-run clears everything
        step(1, 1, 1, 6);
        chk("rst_err_cnt", int'(err_cnt), 0);
        samp(6); samp(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
